// File: rtl/regfile_access_ctrl_if.sv
// Command and response channels between a command source and regfile_access_ctrl.
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid and ready are both high.
interface regfile_access_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Command source / response consumer side.
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for the 8x16 register file: runs single or burst
// write-fill / read commands and returns read data on a valid/ready channel.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_access_ctrl_if.slave  bus,
    output logic                  rf_WrEn,
    output logic                  rf_RdEn,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_WrData,
    input  logic [DATA_WIDTH-1:0] rf_RdData,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_valid_q;
    logic                  accept;
    logic                  advance;
    logic                  last_beat;
    logic                  rsp_hs;

    assign last_beat = (remaining == '0);
    assign rsp_hs    = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = bus.cmd_write ? WR : RD;
                end
            end
            WR: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            RD:  state_nxt = CAP;
            CAP: state_nxt = RESP;
            RESP: begin
                // Nothing moves until the consumer takes the beat.
                if (rsp_hs) begin
                    if (last_beat) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end else begin
                        state_nxt = RD;
                        advance   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur_addr  <= bus.cmd_addr;
                remaining <= bus.cmd_len;
                wdata_q   <= bus.cmd_wdata;
            end else if (advance) begin
                // Address wraps modulo the register file depth.
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == CAP) begin
                rsp_data_q  <= rf_RdData;
                rsp_valid_q <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Strobes decode the state register only, so they cannot glitch or overlap.
    assign rf_WrEn    = (state == WR);
    assign rf_RdEn    = (state == RD);
    assign rf_address = (rf_WrEn || rf_RdEn) ? cur_addr : '0;
    assign rf_WrData  = rf_WrEn ? wdata_q : '0;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file, cycle-level
// reference model, response scoreboard and directed plus random commands.
module tb_regfile_access_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          rf_WrEn;
  logic          rf_RdEn;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_WrData;
  logic [DW-1:0] rf_RdData;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  regfile_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) intf();

  regfile_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (intf),
    .rf_WrEn    (rf_WrEn),
    .rf_RdEn    (rf_RdEn),
    .rf_address (rf_address),
    .rf_WrData  (rf_WrData),
    .rf_RdData  (rf_RdData),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file with registered read data ----------------
  logic [DW-1:0] rf_mem [8] = '{default: '0};
  always @(posedge clk) begin
    if (rf_WrEn) rf_mem[rf_address] <= rf_WrData;
    if (rf_RdEn) rf_RdData <= rf_mem[rf_address];
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- response ready driver ----------------
  // mode 0: always ready, 1: random, 2: low for 5 cycles of every beat
  int rdy_mode = 0;
  int stall_cnt = 0;
  logic hs_seen = 1'b0;
  always @(negedge clk) hs_seen <= intf.rsp_valid && intf.rsp_ready;
  always @(posedge clk) begin
    #1;
    if (hs_seen) stall_cnt = 0;
    if (intf.rsp_valid) stall_cnt++;
    case (rdy_mode)
      0:       intf.rsp_ready = 1'b1;
      1:       intf.rsp_ready = 1'($urandom_range(0, 1));
      default: intf.rsp_ready = (stall_cnt > 5);
    endcase
  end

  // ---------------- reference model and scoreboard ----------------
  logic [DW-1:0] ref_mem [8] = '{default: '0};
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [AW-1:0] rd_addr_log[$];
  logic [DW-1:0] rsp_log[$];
  int            done_cnt = 0;

  bit            m_active = 0;
  bit            m_write = 0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_len = '0;
  logic [DW-1:0] m_data = '0;
  int            m_acc = 0;
  int            m_beat = 0;
  int            m_bstart = 0;

  always @(negedge clk) begin
    bit            e_wr, e_rd, e_vld, e_done, wr_end;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdat;
    int            k;
    cyc++;
    if (!rst) begin
      m_active = 0;
      exp_q.delete();
    end else begin
      e_wr = 0; e_rd = 0; e_vld = 0; e_done = 0; wr_end = 0;
      e_addr = '0; e_rdat = '0; k = 0;
      if (m_active && m_write) begin
        // beat k (1..len+1) of a write lands k cycles after acceptance
        k      = cyc - m_acc;
        e_wr   = 1;
        e_addr = m_addr + AW'(k - 1);
        wr_end = (k == int'(m_len) + 1);
        e_done = wr_end;
      end
      if (m_active && !m_write) begin
        e_addr = m_addr + AW'(m_beat);
        e_rd   = (cyc == m_bstart);
        e_vld  = (cyc >= m_bstart + 2);
        e_rdat = ref_mem[e_addr];
        e_done = e_vld && intf.rsp_ready && (m_beat == int'(m_len));
      end
      check("cmd_ready", 32'(intf.cmd_ready), 32'(!m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("wr_en", 32'(rf_WrEn), 32'(e_wr));
      check("rd_en", 32'(rf_RdEn), 32'(e_rd));
      check("rsp_valid", 32'(intf.rsp_valid), 32'(e_vld));
      check("done", 32'(done), 32'(e_done));
      check("strobe_excl", 32'(rf_WrEn && rf_RdEn), 32'(0));
      if (e_wr) begin
        check("wr_addr", 32'(rf_address), 32'(e_addr));
        check("wr_data", 32'(rf_WrData), 32'(m_data));
      end
      if (e_rd) check("rd_addr", 32'(rf_address), 32'(e_addr));
      if (e_vld) check("rsp_data", 32'(intf.rsp_data), 32'(e_rdat));

      if (rf_WrEn) wr_addr_log.push_back(rf_address);
      if (rf_RdEn) rd_addr_log.push_back(rf_address);
      if (done) done_cnt++;
      if (intf.rsp_valid && intf.rsp_ready) begin
        rsp_log.push_back(intf.rsp_data);
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(intf.rsp_data), 32'hFFFF_FFFF);
        else check("sb_rsp", 32'(intf.rsp_data), 32'(exp_q.pop_front()));
      end

      // advance the model across the coming clock edge
      if (m_active && m_write) begin
        if (wr_end) m_active = 0;
      end else if (m_active && !m_write) begin
        if (e_vld && intf.rsp_ready) begin
          if (m_beat == int'(m_len)) m_active = 0;
          else begin
            m_beat++;
            m_bstart = cyc + 1;
          end
        end
      end else if (intf.cmd_valid) begin
        m_active = 1;
        m_write  = intf.cmd_write;
        m_addr   = intf.cmd_addr;
        m_len    = intf.cmd_len;
        m_data   = intf.cmd_wdata;
        m_acc    = cyc;
        m_beat   = 0;
        m_bstart = cyc + 1;
        for (int i = 0; i <= int'(m_len); i++) begin
          if (m_write) ref_mem[m_addr + AW'(i)] = m_data;
          else exp_q.push_back(ref_mem[m_addr + AW'(i)]);
        end
      end
    end
  end

  // ---------------- driver tasks (return just after a rising edge) ----------------
  task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input logic [DW-1:0] d);
    int n;
    n = 0;
    intf.cmd_valid = 1'b1;
    intf.cmd_write = w;
    intf.cmd_addr  = a;
    intf.cmd_len   = l;
    intf.cmd_wdata = d;
    @(negedge clk);
    while (!intf.cmd_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check("cmd_accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    intf.cmd_valid = 1'b0;
    intf.cmd_write = 1'($urandom_range(0, 1));
    intf.cmd_addr  = AW'($urandom_range(0, 7));
    intf.cmd_len   = AW'($urandom_range(0, 7));
    intf.cmd_wdata = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) check("idle_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base_wr, base_rd, base_rsp, base_done;
    rst = 1'b0;
    intf.cmd_valid = 1'b0;
    intf.cmd_write = 1'b0;
    intf.cmd_addr  = '0;
    intf.cmd_len   = '0;
    intf.cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_wr_en", 32'(rf_WrEn), 32'(0));
    check("rst_rd_en", 32'(rf_RdEn), 32'(0));
    check("rst_rsp_valid", 32'(intf.rsp_valid), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_addr", 32'(rf_address), 32'(0));
    check("rst_wdata", 32'(rf_WrData), 32'(0));
    check("rst_rsp_data", 32'(intf.rsp_data), 32'(0));
    check("rst_cmd_ready", 32'(intf.cmd_ready), 32'(1));
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // single write then single read of address 2
    base_wr = wr_addr_log.size(); base_done = done_cnt;
    send_cmd(1'b1, 3'd2, 3'd0, 16'hA5A5);
    wait_idle();
    check("single_wr_count", 32'(wr_addr_log.size() - base_wr), 32'(1));
    check("single_wr_addr", 32'(wr_addr_log[base_wr]), 32'(2));
    check("single_wr_done", 32'(done_cnt - base_done), 32'(1));
    base_done = done_cnt;
    send_cmd(1'b0, 3'd2, 3'd0, 16'h0000);
    @(posedge clk); #2;
    check("rd_lat_c2_valid", 32'(intf.rsp_valid), 32'(0));
    @(posedge clk); #2;
    check("rd_lat_c3_valid", 32'(intf.rsp_valid), 32'(1));
    check("rd_lat_c3_data", 32'(intf.rsp_data), 32'hA5A5);
    wait_idle();
    check("single_rd_done", 32'(done_cnt - base_done), 32'(1));

    // write fill across the wrap
    base_wr = wr_addr_log.size();
    send_cmd(1'b1, 3'd6, 3'd3, 16'h1234);
    wait_idle();
    check("fill_count", 32'(wr_addr_log.size() - base_wr), 32'(4));
    check("fill_addr0", 32'(wr_addr_log[base_wr + 0]), 32'(6));
    check("fill_addr1", 32'(wr_addr_log[base_wr + 1]), 32'(7));
    check("fill_addr2", 32'(wr_addr_log[base_wr + 2]), 32'(0));
    check("fill_addr3", 32'(wr_addr_log[base_wr + 3]), 32'(1));

    // read burst across the wrap
    base_wr = wr_addr_log.size(); base_rd = rd_addr_log.size(); base_rsp = rsp_log.size();
    send_cmd(1'b0, 3'd6, 3'd3, 16'h0000);
    wait_idle();
    check("rdb_no_wr", 32'(wr_addr_log.size() - base_wr), 32'(0));
    check("rdb_beats", 32'(rsp_log.size() - base_rsp), 32'(4));
    for (int i = 0; i < 4; i++) check("rdb_data", 32'(rsp_log[base_rsp + i]), 32'h1234);
    check("rdb_addr0", 32'(rd_addr_log[base_rd + 0]), 32'(6));
    check("rdb_addr3", 32'(rd_addr_log[base_rd + 3]), 32'(1));

    // read burst under heavy backpressure
    rdy_mode = 2;
    base_rd = rd_addr_log.size(); base_rsp = rsp_log.size();
    send_cmd(1'b0, 3'd6, 3'd2, 16'h0000);
    wait_idle();
    check("stall_rd_strobes", 32'(rd_addr_log.size() - base_rd), 32'(3));
    check("stall_beats", 32'(rsp_log.size() - base_rsp), 32'(3));
    rdy_mode = 0;

    // back-to-back: command held valid while a write burst runs
    base_done = done_cnt;
    send_cmd(1'b1, 3'd0, 3'd7, 16'h5AC3);
    send_cmd(1'b0, 3'd3, 3'd1, 16'h0000);
    wait_idle();
    check("b2b_done", 32'(done_cnt - base_done), 32'(2));

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      rdy_mode = $urandom_range(0, 2);
      send_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               AW'($urandom_range(0, 7)), DW'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    rdy_mode = 0;
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    // reset in the middle of a read burst
    send_cmd(1'b0, 3'd0, 3'd7, 16'h0000);
    repeat (4) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort_wr_en", 32'(rf_WrEn), 32'(0));
    check("abort_rd_en", 32'(rf_RdEn), 32'(0));
    check("abort_rsp_valid", 32'(intf.rsp_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_cmd_ready", 32'(intf.cmd_ready), 32'(1));
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    base_rsp = rsp_log.size();
    send_cmd(1'b0, 3'd6, 3'd0, 16'h0000);
    wait_idle();
    check("post_abort_beats", 32'(rsp_log.size() - base_rsp), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
